// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, bit-reverse helper and read-state
// type for the FFT output reorder path.
package fft_pkg;

  localparam int LOGN = 6;
  localparam int N    = 1 << LOGN;
  localparam int DW   = 16;

  typedef enum logic {
    R_IDLE,
    R_STREAM
  } rstate_t;

  function automatic logic [LOGN-1:0] bitrev(
    input logic [LOGN-1:0] a
  );
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = a[LOGN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of N x {re,im}; one write port, one
// read port with enable and a registered output.
// Ports: clk, nrst, we/waddr/wdata, re/raddr, rdata.
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            we,
  input  logic [LOGN:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic            re,
  input  logic [LOGN:0]   raddr,
  output logic [2*DW-1:0] rdata
);

  // Storage array carries no reset; only the read register clears.
  logic [2*DW-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer taking bit-reversed FFT frames
// and streaming them out in natural order over ready/valid.
// Ports: clk, nrst, in_valid/in_sof/in_re/in_im -> in_ready, ovf;
// out_valid/out_re/out_im/out_idx/out_last <- out_ready.
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  output logic            in_ready,
  output logic            ovf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [LOGN-1:0] out_idx,
  output logic            out_last
);

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  logic            wbank;
  logic            rbank;
  logic            rbank_nxt;
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic [LOGN-1:0] wcnt;
  logic [LOGN-1:0] waddr;
  logic [LOGN-1:0] rcnt;
  logic [LOGN-1:0] rcnt_nxt;
  logic [LOGN-1:0] idx_nxt;
  logic            vld_nxt;
  rstate_t         state;
  rstate_t         state_nxt;
  logic            acc;
  logic            set;
  logic            clr;
  logic            ren;
  logic            adv;
  logic [2*DW-1:0] rdata;

  assign in_ready = ~full[wbank];
  assign acc      = in_valid & in_ready;
  // SOF restarts the frame at address 0, abandoning any partial one.
  assign waddr    = in_sof ? '0 : bitrev(wcnt);
  assign set      = acc & ~in_sof & (wcnt == LAST);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ovf <= in_valid & ~in_ready;
      if (acc) begin
        if (in_sof) begin
          wcnt <= LOGN'(1);
        end else begin
          wcnt <= wcnt + LOGN'(1);
        end
        if (set) begin
          wbank <= ~wbank;
        end
      end
    end
  end

  // Set and clear always target different banks.
  always_comb begin
    full_nxt = full;
    if (set) begin
      full_nxt[wbank] = 1'b1;
    end
    if (clr) begin
      full_nxt[rbank] = 1'b0;
    end
  end

  assign adv = ~out_valid | out_ready;

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rbank_nxt = rbank;
    vld_nxt   = out_valid;
    idx_nxt   = out_idx;
    ren       = 1'b0;
    clr       = 1'b0;
    unique case (state)
      R_IDLE: begin
        if (adv) begin
          vld_nxt = 1'b0;
        end
        if (full[rbank]) begin
          state_nxt = R_STREAM;
          rcnt_nxt  = '0;
        end
      end
      R_STREAM: begin
        if (adv) begin
          ren      = 1'b1;
          vld_nxt  = 1'b1;
          idx_nxt  = rcnt;
          rcnt_nxt = rcnt + LOGN'(1);
          if (rcnt == LAST) begin
            clr       = 1'b1;
            rbank_nxt = ~rbank;
            state_nxt = full[~rbank] ? R_STREAM : R_IDLE;
          end
        end
      end
      default: begin
        state_nxt = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= R_IDLE;
      rcnt      <= '0;
      rbank     <= 1'b0;
      full      <= 2'b00;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      state     <= state_nxt;
      rcnt      <= rcnt_nxt;
      rbank     <= rbank_nxt;
      full      <= full_nxt;
      out_valid <= vld_nxt;
      out_idx   <= idx_nxt;
    end
  end

  assign out_re   = rdata[2*DW-1:DW];
  assign out_im   = rdata[DW-1:0];
  assign out_last = out_valid & (out_idx == LAST);

  fft_pingpong_ram u_ram (
    .clk   (clk),
    .nrst  (nrst),
    .we    (acc),
    .waddr ({wbank, waddr}),
    .wdata ({in_re, in_im}),
    .re    (ren),
    .raddr ({rbank, rcnt}),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: scoreboard bench for the FFT output reorder
// buffer; scenario table plus hand-written corner sequences.
module tb_fft_out_reorder;
  import fft_pkg::*;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_sof = 1'b0;
  logic [DW-1:0]   in_re = '0;
  logic [DW-1:0]   in_im = '0;
  logic            in_ready;
  logic            ovf;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_re;
  logic [DW-1:0]   out_im;
  logic [LOGN-1:0] out_idx;
  logic            out_last;

  fft_out_reorder dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_ready  (in_ready),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   re;
    logic [DW-1:0]   im;
    logic [LOGN-1:0] idx;
  } exp_t;

  typedef struct {
    int nfr;
    int rmode;
    int exp_out;
    bit contig;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   tag = 0;
  int   rmode = 0;
  int   nxfer = 0;
  int   ovf_cnt = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   first_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  logic            pv = 1'b0;
  logic            pr = 1'b0;
  logic [DW-1:0]   pre, pim;
  logic [LOGN-1:0] pidx;
  logic            plast;

  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      if (ovf) ovf_cnt++;
      if (pv && !pr) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_re", 32'(out_re), 32'(pre));
        chk("stall_im", 32'(out_im), 32'(pim));
        chk("stall_idx", 32'(out_idx), 32'(pidx));
        chk("stall_last", 32'(out_last), 32'(plast));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_output", 32'(out_idx), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_re", 32'(out_re), 32'(e.re));
          chk("out_im", 32'(out_im), 32'(e.im));
          chk("out_idx", 32'(out_idx), 32'(e.idx));
          chk("out_last", 32'(out_last),
              32'(e.idx == LOGN'(N - 1)));
        end
        if (!first_seen) begin
          first_cyc  = cyc;
          first_seen = 1;
        end
        last_cyc = cyc;
        nxfer++;
      end
      pv = out_valid;
    end else begin
      pv = 1'b0;
    end
    pr    = out_ready;
    pre   = out_re;
    pim   = out_im;
    pidx  = out_idx;
    plast = out_last;
  end

  // n samples in bit-reversed order, SOF on the first; polite waits
  // for in_ready before presenting each sample.
  task automatic send_frame(input int n, input bit polite);
    exp_t            fr[N];
    logic [LOGN-1:0] k;
    logic [DW-1:0]   re;
    logic [DW-1:0]   im;
    bit              ok;
    bit              acc;
    int              w;
    ok = 1;
    for (int j = 0; j < n; j++) begin
      k  = bitrev(LOGN'(j));
      re = DW'(tag * N + int'(k));
      im = re ^ 16'hA5C3;
      w  = 0;
      @(negedge clk);
      while (polite && !in_ready && w < 2000) begin
        in_valid = 1'b0;
        @(negedge clk);
        w++;
      end
      in_valid = 1'b1;
      in_sof   = (j == 0);
      in_re    = re;
      in_im    = im;
      acc      = in_ready;
      @(posedge clk);
      if (!acc) ok = 0;
      fr[k] = '{re, im, k};
    end
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (polite) chk("input_accept", 32'(ok), 32'd1);
    if (n == N && ok) begin
      for (int i = 0; i < N; i++) sb.push_back(fr[i]);
    end
    tag++;
  endtask

  task automatic drain(input int budget);
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  vec_t tbl[4];

  initial begin
    int x0;
    int o0;
    int w;
    tbl[0] = '{1, 0, 64, 1};
    tbl[1] = '{3, 0, 192, 0};
    tbl[2] = '{2, 1, 128, 0};
    tbl[3] = '{3, 1, 192, 0};

    rmode = 0;
    nrst  = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_re", 32'(out_re), 32'd0);
    chk("rst_out_im", 32'(out_im), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);

    // Latency: first valid two edges after the last accept.
    x0 = nxfer;
    send_frame(N, 1);
    @(negedge clk);
    chk("lat_t0_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2_valid", 32'(out_valid), 32'd1);
    chk("lat_t2_idx", 32'(out_idx), 32'd0);
    drain(500);
    chk("lat_count", 32'(nxfer - x0), 32'd64);

    for (int i = 0; i < 4; i++) begin
      rmode = tbl[i].rmode;
      x0 = nxfer;
      o0 = ovf_cnt;
      first_seen = 0;
      for (int f = 0; f < tbl[i].nfr; f++) send_frame(N, 1);
      drain(3000);
      rmode = 0;
      chk("tbl_count", 32'(nxfer - x0), 32'(tbl[i].exp_out));
      chk("tbl_ovf", 32'(ovf_cnt - o0), 32'd0);
      if (tbl[i].contig) begin
        chk("tbl_contig", 32'(last_cyc - first_cyc),
            32'(tbl[i].exp_out - 1));
      end
    end

    // SOF mid-frame drops the partial frame.
    x0 = nxfer;
    send_frame(20, 0);
    send_frame(N, 1);
    drain(500);
    chk("sof_count", 32'(nxfer - x0), 32'd64);

    // Both banks full with output stalled; third frame overflows.
    rmode = 2;
    x0 = nxfer;
    o0 = ovf_cnt;
    send_frame(N, 0);
    send_frame(N, 0);
    @(negedge clk);
    chk("both_full_ready", 32'(in_ready), 32'd0);
    send_frame(5, 0);
    repeat (3) @(negedge clk);
    chk("ovf_pulses", 32'(ovf_cnt - o0), 32'd5);
    rmode = 0;
    drain(1000);
    chk("ovf_count", 32'(nxfer - x0), 32'd128);

    // Reset while draining at index 30.
    send_frame(N, 1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(out_valid && out_ready && out_idx == 30) && w < 200);
    chk("rst_wait_idx30", 32'(w < 200), 32'd1);
    #1 nrst = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_idx", 32'(out_idx), 32'd0);
    sb.delete();
    x0 = nxfer;
    send_frame(N, 1);
    drain(500);
    chk("post_rst_count", 32'(nxfer - x0), 32'd64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
